// File: rtl/hi_flite_pkg.sv
// hi_flite_pkg: shared types and constants for the FeliCa response slot scheduler.
package hi_flite_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SEND  = 2'd2,
    GUARD = 2'd3
  } state_e;

  localparam int unsigned BIT_TICKS_212   = 64;
  localparam int unsigned BIT_TICKS_424   = 32;

  localparam int unsigned TS0_TICKS_DEF   = 32768;
  localparam int unsigned TSLOT_TICKS_DEF = 16384;
  localparam int unsigned GUARD_TICKS_DEF = 128;
  localparam int unsigned CNT_W_DEF       = 19;

  localparam int unsigned TICK_W = 6;
  localparam int unsigned BITS_W = 12;
  localparam int unsigned SLOT_W = 4;

  // Response parameters captured at the slot deadline.
  typedef struct packed {
    logic              speed;
    logic [BITS_W-1:0] bits;
  } tx_cfg_t;

endpackage

// File: rtl/hi_flite_slot_sched_if.sv
// hi_flite_slot_sched_if: demodulator events, ARM response request and the
// modulator-facing outputs of the slot scheduler.
//   master: drives speed, frame_start, frame_end, slot, tx_req, tx_bits;
//           observes mod_en, bit_half, tx_bit_stb, busy, done, missed
//   slave : the scheduler side of the same signals
interface hi_flite_slot_sched_if;
  logic                            speed;
  logic                            frame_start;
  logic                            frame_end;
  logic [hi_flite_pkg::SLOT_W-1:0] slot;
  logic                            tx_req;
  logic [hi_flite_pkg::BITS_W-1:0] tx_bits;
  logic                            mod_en;
  logic                            bit_half;
  logic                            tx_bit_stb;
  logic                            busy;
  logic                            done;
  logic                            missed;

  modport master (
    output speed, frame_start, frame_end, slot, tx_req, tx_bits,
    input  mod_en, bit_half, tx_bit_stb, busy, done, missed
  );

  modport slave (
    input  speed, frame_start, frame_end, slot, tx_req, tx_bits,
    output mod_en, bit_half, tx_bit_stb, busy, done, missed
  );
endinterface

// File: rtl/hi_flite_bit_timer.sv
// hi_flite_bit_timer: Manchester bit timing inside the modulation window.
//   en         : window is open on the next cycle
//   load       : window not open this cycle (restart at bit 0, tick 0)
//   speed      : latched rate, 0 = 64 ticks/bit, 1 = 32 ticks/bit
//   tx_bits    : latched response length
//   tx_bit_stb : registered pulse at tick 0 of every bit
//   bit_half   : registered, high in the second half of the bit
//   last_bit_c : combinational, final tick of the final bit
module hi_flite_bit_timer
  import hi_flite_pkg::*;
(
  input  logic              ck_1356meg,
  input  logic              reset_n,
  input  logic              en,
  input  logic              load,
  input  logic              speed,
  input  logic [BITS_W-1:0] tx_bits,
  output logic              tx_bit_stb,
  output logic              bit_half,
  output logic              last_bit_c
);

  logic [TICK_W-1:0] tick_q, tick_nxt, tick_max, tick_half;
  logic [BITS_W-1:0] bit_q, bit_nxt;

  // Next tick/bit position; everything returns to zero when the window closes.
  always_comb begin
    tick_max  = speed ? TICK_W'(BIT_TICKS_424 - 1) : TICK_W'(BIT_TICKS_212 - 1);
    tick_half = speed ? TICK_W'(BIT_TICKS_424 / 2) : TICK_W'(BIT_TICKS_212 / 2);
    tick_nxt  = '0;
    bit_nxt   = '0;
    if (en && !load) begin
      if (tick_q == tick_max) begin
        tick_nxt = '0;
        bit_nxt  = bit_q + BITS_W'(1);
      end else begin
        tick_nxt = tick_q + TICK_W'(1);
        bit_nxt  = bit_q;
      end
    end
  end

  assign last_bit_c = (tick_q == tick_max) && (bit_q == tx_bits - BITS_W'(1));

  always_ff @(posedge ck_1356meg or negedge reset_n) begin
    if (!reset_n) begin
      tick_q     <= '0;
      bit_q      <= '0;
      tx_bit_stb <= 1'b0;
      bit_half   <= 1'b0;
    end else begin
      tick_q     <= tick_nxt;
      bit_q      <= bit_nxt;
      tx_bit_stb <= en && (tick_nxt == '0);
      bit_half   <= en && (tick_nxt >= tick_half);
    end
  end

endmodule

// File: rtl/hi_flite_slot_sched.sv
// hi_flite_slot_sched: times the tag reply after a reader frame (Tdelay plus
// slot * Tslot), opens the modulation window for the requested bit count, then
// holds a guard period before accepting the next frame.
//   ck_1356meg : carrier clock, one tick per fc cycle
//   reset_n    : asynchronous active-low reset
//   bus        : event inputs, response request and registered outputs
module hi_flite_slot_sched
  import hi_flite_pkg::*;
#(
  parameter int unsigned TS0_TICKS   = TS0_TICKS_DEF,
  parameter int unsigned TSLOT_TICKS = TSLOT_TICKS_DEF,
  parameter int unsigned GUARD_TICKS = GUARD_TICKS_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input logic                  ck_1356meg,
  input logic                  reset_n,
  hi_flite_slot_sched_if.slave bus
);

  state_e           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt, delay_c;
  tx_cfg_t          cfg_q, cfg_nxt;
  logic             mod_en_q, busy_q, done_q, done_nxt, missed_q, missed_nxt;
  logic             timer_en, timer_load, last_bit_c, stb, half;

  // Reload value D-1 for the slot sampled this cycle.
  assign delay_c = CNT_W'(TS0_TICKS) + CNT_W'(bus.slot) * CNT_W'(TSLOT_TICKS) - CNT_W'(1);

  // Scheduler next state; one shared counter times both the slot delay and the guard.
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    cfg_nxt    = cfg_q;
    done_nxt   = 1'b0;
    missed_nxt = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.frame_end) begin
          state_nxt = WAIT;
          cnt_nxt   = delay_c;
        end
      end
      WAIT: begin
        // frame_start outranks both a restart and the deadline.
        if (bus.frame_start) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (bus.frame_end) begin
          cnt_nxt = delay_c;
        end else if (cnt_q != '0) begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end else if (!bus.tx_req) begin
          state_nxt  = IDLE;
          missed_nxt = 1'b1;
        end else if (bus.tx_bits == '0) begin
          state_nxt = GUARD;
          cnt_nxt   = CNT_W'(GUARD_TICKS - 1);
        end else begin
          state_nxt     = SEND;
          cfg_nxt.speed = bus.speed;
          cfg_nxt.bits  = bus.tx_bits;
        end
      end
      SEND: begin
        // Reader events here are the echo of our own load modulation.
        if (!bus.tx_req || last_bit_c) begin
          state_nxt = GUARD;
          cnt_nxt   = CNT_W'(GUARD_TICKS - 1);
        end
      end
      GUARD: begin
        if (cnt_q == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign timer_en   = (state_nxt == SEND);
  assign timer_load = (state_q != SEND);

  hi_flite_bit_timer u_bit_timer (
    .ck_1356meg (ck_1356meg),
    .reset_n    (reset_n),
    .en         (timer_en),
    .load       (timer_load),
    .speed      (cfg_q.speed),
    .tx_bits    (cfg_q.bits),
    .tx_bit_stb (stb),
    .bit_half   (half),
    .last_bit_c (last_bit_c)
  );

  always_ff @(posedge ck_1356meg or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cfg_q    <= '0;
      mod_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      cfg_q    <= cfg_nxt;
      mod_en_q <= (state_nxt == SEND);
      busy_q   <= (state_q != IDLE);
      done_q   <= done_nxt;
      missed_q <= missed_nxt;
    end
  end

  assign bus.mod_en     = mod_en_q;
  assign bus.bit_half   = half;
  assign bus.tx_bit_stb = stb;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.missed     = missed_q;

endmodule

// File: doc/hi_flite_slot_sched.md
# hi_flite_slot_sched

Response timeslot scheduler for the ISO/IEC 18092 (FeliCa / NFC Type 3) 13.56 MHz tag-emulation path. It times the tag reply relative to the end of a reader frame: the Tdelay of 512·64/fc plus the selected slot × 256·64/fc. It then opens the modulation window for exactly the requested number of Manchester bits, producing per-bit strobes and the half-bit phase consumed by the modulator. It sits between the envelope demodulator (frame start/end events), the ARM-fed SSP transmit shifter and the pwr_oe4 modulation driver.

## Interface
- TS0_TICKS, 32768: carrier ticks from frame_end to the slot-0 start.
- TSLOT_TICKS, 16384: carrier ticks per additional slot.
- GUARD_TICKS, 128: quiet ticks after transmit before a new frame is accepted.
- CNT_W, 19: delay counter width. Must hold TS0_TICKS + 15·TSLOT_TICKS = 278528.
- ck_1356meg  in  1  carrier clock, one tick per fc cycle.
- reset_n  in  1  asynchronous active-low reset.
- speed  in  1  0 = 212 kbps (64 ticks/bit), 1 = 424 kbps (32 ticks/bit).
- frame_start  in  1  one-cycle pulse when the demodulator detects reader modulation.
- frame_end  in  1  one-cycle pulse when the demodulator declares the frame over.
- slot  in  4  timeslot number, 0..15.
- tx_req  in  1  level; ARM has a response armed.
- tx_bits  in  12  response length in bits, preamble included.
- mod_en  out  1  modulation window open.
- bit_half  out  1  0 in the first half of the current bit, 1 in the second half.
- tx_bit_stb  out  1  one-cycle pulse at every bit start; the shifter advances on it.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse at the end of GUARD.
- missed  out  1  one-cycle pulse when the slot deadline passes with tx_req low.

## Operation
- States:
  - IDLE: no frame being timed.
  - WAIT: counting down to the slot start.
  - SEND: modulation window open.
  - GUARD: post-transmit quiet period.
- IDLE → WAIT on frame_end. The delay counter loads D−1, where D = TS0_TICKS + slot·TSLOT_TICKS. slot is latched on this cycle.
- WAIT:
  - frame_start → IDLE (reader is still talking; the frame is discarded).
  - frame_end → reload the counter with the newly sampled slot (restart).
  - On counter = 0:
    - tx_req=1 and tx_bits≠0 → SEND. speed and tx_bits are latched.
    - tx_req=1 and tx_bits=0 → GUARD, with no modulation.
    - tx_req=0 → pulse missed, go to IDLE.
- SEND:
  - Bit timer counts P ticks per bit, where P = 64 or 32 from the latched speed.
  - bit_half = (tick ≥ P/2).
  - tx_bit_stb pulses at tick 0 of each bit.
  - After tx_bits full bits → GUARD.
  - frame_start and frame_end are ignored in SEND; the echo of our own modulation is expected.
  - tx_req falling mid-bit → abort: mod_en drops on the next cycle, then GUARD.
- GUARD: counts GUARD_TICKS. frame_start and frame_end are ignored. On expiry, pulse done and go to IDLE.
- Simultaneous events:
  - frame_start and frame_end on the same cycle in WAIT: frame_start wins.
  - Counter reaching 0 on the same cycle as frame_start: frame_start wins (abort, no missed pulse).
- Reset (any time, including mid-SEND):
  - State IDLE, all counters 0.
  - mod_en, bit_half, tx_bit_stb, busy, done and missed all 0.
  - mod_en deasserts asynchronously with reset.
- Arithmetic rules:
  - D is computed at CNT_W bits and must not overflow.
  - The bit counter is 12 bits and compares against the latched tx_bits.
  - The in-bit tick counter is 6 bits and wraps at P−1.

## Timing
- Relative to frame_end sampled at cycle t:
  - busy rises at t+1.
  - mod_en and the first tx_bit_stb are registered high at cycle t+D.
  - missed (tx_req low at the deadline) pulses at t+D.
- mod_en covers exactly tx_bits·P cycles and falls at t+D+tx_bits·P.
- bit_half rises P/2 cycles after each tx_bit_stb.
- done pulses at t+D+tx_bits·P+GUARD_TICKS; busy falls on the following cycle.
- All outputs are registered; there is no combinational path from any input to an output.

## Structure
- Package hi_flite_pkg holds:
  - the state enum (IDLE, WAIT, SEND, GUARD);
  - the constants BIT_TICKS_212 = 64 and BIT_TICKS_424 = 32;
  - the default TS0/TSLOT/GUARD values.
- One sub-module, hi_flite_bit_timer, is natural. It takes the latched speed and an enable, and produces tx_bit_stb, bit_half and a bit-count-done flag from tx_bits. The scheduler FSM and the delay/guard counter stay at the top level.

## Test plan
- frame_end at cycle 100, slot=0, tx_req=1, tx_bits=16, speed=0 → mod_en high on cycles 32868..33891; 16 tx_bit_stb pulses spaced 64 apart; done at 34020.
- slot=2, speed=1, tx_bits=8, frame_end at 100 → mod_en rises at 65636 and falls at 65892; bit_half toggles every 16 cycles.
- tx_req=0 at the deadline, slot=0, frame_end at 0 → missed pulses at 32768; mod_en never rises; busy low from 32769.
- frame_start at cycle 1000 during WAIT → IDLE at 1001; no mod_en, no missed. A second frame_end at 2000 → mod_en at 34768.
- tx_req drops at the 5th bit during SEND → mod_en low on the next cycle; done exactly GUARD_TICKS later; no further tx_bit_stb.
- reset_n asserted mid-SEND → mod_en 0 immediately; after release, state is IDLE and busy=0.
